// File: rtl/p2s_pkg.sv
// Shared types and constants for the parallel-to-serial word serializer.
// P2S_CHECKSUM_EN appends an XOR checksum beat after y1 and moves the last beat to 8.
package p2s_pkg;

  localparam int FRAME_WORDS = 8;
  localparam int CNT_W       = 4;

  typedef enum logic {
    P2S_IDLE  = 1'b0,
    P2S_SHIFT = 1'b1
  } p2s_state_e;

`ifdef P2S_CHECKSUM_EN
  localparam logic [CNT_W-1:0] LAST_BEAT = 4'd8;
`else
  localparam logic [CNT_W-1:0] LAST_BEAT = 4'd7;
`endif

  // Beat counter advance that never runs past the final beat of a frame.
  function automatic logic [CNT_W-1:0] p2s_next_cnt(input logic [CNT_W-1:0] cnt);
    return (cnt == LAST_BEAT) ? '0 : cnt + CNT_W'(1);
  endfunction

endpackage

// File: rtl/p2s_word_serializer_if.sv
// Frame-in / word-stream-out handshake bundle for p2s_word_serializer.
// master = frame producer and stream consumer (test side), slave = the serializer.
interface p2s_word_serializer_if #(
  parameter int W = 16
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] y1, y2, y3, y4, y5, y6, y7, y8;
  logic [W-1:0] q;
  logic         q_valid;
  logic         q_ready;
  logic         q_last;

  modport master (
    output in_valid, y1, y2, y3, y4, y5, y6, y7, y8, q_ready,
    input  in_ready, q, q_valid, q_last
  );

  modport slave (
    input  in_valid, y1, y2, y3, y4, y5, y6, y7, y8, q_ready,
    output in_ready, q, q_valid, q_last
  );
endinterface

// File: rtl/p2s_frame_buffer.sv
// Eight-word frame holding registers with a load enable and a beat-indexed read mux.
// With P2S_CHECKSUM_EN a ninth register captures the XOR of the frame at load time.
import p2s_pkg::*;

module p2s_frame_buffer #(
  parameter int W = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            load,
  input  logic [FRAME_WORDS-1:0][W-1:0]   din,     // din[0] is the first word out (y8)
  input  logic [CNT_W-1:0]                rd_idx,
  output logic [W-1:0]                    rd_data
);

  logic [FRAME_WORDS-1:0][W-1:0] words_rd;

  genvar gi;
  generate
    for (gi = 0; gi < FRAME_WORDS; gi++) begin : g_word
      logic [W-1:0] word_q;
      logic [W-1:0] word_d;

      always_comb begin
        word_d = word_q;
        if (load) begin
          word_d = din[gi];
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          word_q <= '0;
        end else begin
          word_q <= word_d;
        end
      end

      assign words_rd[gi] = word_q;
    end
  endgenerate

`ifdef P2S_CHECKSUM_EN
  logic [W-1:0] chk_q;
  logic [W-1:0] chk_d;

  always_comb begin
    chk_d = chk_q;
    if (load) begin
      chk_d = '0;
      for (int i = 0; i < FRAME_WORDS; i++) begin
        chk_d = chk_d ^ din[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      chk_q <= '0;
    end else begin
      chk_q <= chk_d;
    end
  end
`endif

  // Full-width compare keeps out-of-range indices reading zero.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < FRAME_WORDS; i++) begin
      if (rd_idx == CNT_W'(i)) begin
        rd_data = words_rd[i];
      end
    end
`ifdef P2S_CHECKSUM_EN
    if (rd_idx == LAST_BEAT) begin
      rd_data = chk_q;
    end
`endif
  end

endmodule

// File: rtl/p2s_word_serializer.sv
// Takes an eight-word frame in one handshake and replays it y8..y1 on a valid/ready stream.
// Optional P2S_CHECKSUM_EN appends an XOR checksum beat carrying q_last.
import p2s_pkg::*;

module p2s_word_serializer #(
  parameter int N = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  p2s_word_serializer_if.slave  bus
);

  localparam int W = 1 << N;

  p2s_state_e                    state_q, state_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic                          in_ready;
  logic                          q_valid;
  logic                          q_last;
  logic [W-1:0]                  q;
  logic                          at_last;
  logic                          frame_xfer;
  logic                          beat_done;
  logic [FRAME_WORDS-1:0][W-1:0] frame_words;
  logic [W-1:0]                  rd_word;

  // Oldest word sits at index 0 so the counter value is the output order.
  assign frame_words = {bus.y1, bus.y2, bus.y3, bus.y4, bus.y5, bus.y6, bus.y7, bus.y8};

  assign at_last    = (cnt_q == LAST_BEAT);
  assign frame_xfer = bus.in_valid && in_ready;
  assign beat_done  = q_valid && bus.q_ready;

  p2s_frame_buffer #(
    .W (W)
  ) u_frame_buffer (
    .clk     (clk),
    .rst     (rst),
    .load    (frame_xfer),
    .din     (frame_words),
    .rd_idx  (cnt_q),
    .rd_data (rd_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= P2S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      P2S_IDLE: begin
        if (frame_xfer) begin
          state_d = P2S_SHIFT;
          cnt_d   = '0;
        end
      end
      P2S_SHIFT: begin
        if (beat_done) begin
          cnt_d = p2s_next_cnt(cnt_q);
          // A frame offered on the final beat is taken with no idle gap.
          if (at_last) begin
            state_d = frame_xfer ? P2S_SHIFT : P2S_IDLE;
          end
        end
      end
      default: begin
        state_d = P2S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    q_valid  = 1'b0;
    q_last   = 1'b0;
    q        = '0;
    case (state_q)
      P2S_IDLE: begin
        in_ready = !rst;
      end
      P2S_SHIFT: begin
        q_valid  = 1'b1;
        q_last   = at_last;
        q        = rd_word;
        in_ready = !rst && at_last && bus.q_ready;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  assign bus.in_ready = in_ready;
  assign bus.q_valid  = q_valid;
  assign bus.q_last   = q_last;
  assign bus.q        = q;

endmodule
